// File: rtl/telemetry_pkg.sv
// Shared types and constants for the eBike telemetry receiver.
// Optional statistics counters are enabled with the TELEM_STATS_EN macro.
package telemetry_pkg;

  localparam logic [7:0] HDR_BYTE0     = 8'hAA;
  localparam logic [7:0] HDR_BYTE1     = 8'h55;
  localparam int         PAYLOAD_BYTES = 6;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} byte_state_t;

  typedef enum logic [1:0] {HDR0, HDR1, PAYLD} pkt_state_t;

  typedef struct packed {
    logic [11:0] batt;
    logic [11:0] curr;
    logic [11:0] torque;
  } telem_t;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: RX synchronizer, mid-bit sampling byte FSM and baud counter.
// Produces one-cycle byte_done / frm_err pulses; rx_byte is valid with byte_done.
module uart_rx_byte
  import telemetry_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       frm_err
);

  localparam int                 CNT_W    = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0]   HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta;
  logic             rx_sync;
  byte_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Counter restarts at each sample so data and stop bits land CLKS_PER_BIT apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      byte_done <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      frm_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_CNT) begin
            cnt <= '0;
            if (!rx_sync) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_CNT) begin
            cnt   <= '0;
            shift <= {rx_sync, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == FULL_CNT) begin
            cnt       <= '0;
            state     <= IDLE;
            byte_done <= rx_sync;
            frm_err   <= !rx_sync;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_byte = shift;

endmodule

// File: rtl/telemetry_rx.sv
// Telemetry packet receiver: locks onto the AA 55 header and latches battery,
// current and torque words. Define TELEM_STATS_EN to add pkt_cnt / err_cnt.
module telemetry_rx
  import telemetry_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        clr_rdy,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_rdy,
  output logic        frm_err
`ifdef TELEM_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [7:0]  err_cnt
`endif
);

  localparam logic [2:0] LAST_IDX = 3'(PAYLOAD_BYTES - 1);

  logic [7:0] rx_byte;
  logic       byte_done;
  pkt_state_t pkt_state;
  logic [2:0] idx;
  logic [3:0] batt_hi;
  logic [7:0] batt_lo;
  logic [3:0] curr_hi;
  logic [7:0] curr_lo;
  logic [3:0] torque_hi;
  telem_t     telem;
  logic       pkt_done;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (RX),
    .rx_byte  (rx_byte),
    .byte_done(byte_done),
    .frm_err  (frm_err)
  );

  assign pkt_done = byte_done && (pkt_state == PAYLD) && (idx == LAST_IDX);

  // Partial payload is staged; the visible words only change when byte 5 lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_state <= HDR0;
      idx       <= '0;
      batt_hi   <= '0;
      batt_lo   <= '0;
      curr_hi   <= '0;
      curr_lo   <= '0;
      torque_hi <= '0;
      telem     <= '0;
    end else if (frm_err) begin
      pkt_state <= HDR0;
    end else if (byte_done) begin
      case (pkt_state)
        HDR0: begin
          if (rx_byte == HDR_BYTE0) pkt_state <= HDR1;
        end
        HDR1: begin
          if (rx_byte == HDR_BYTE1) begin
            pkt_state <= PAYLD;
            idx       <= '0;
          end else if (rx_byte != HDR_BYTE0) begin
            pkt_state <= HDR0;
          end
        end
        PAYLD: begin
          case (idx)
            3'd0:    batt_hi   <= rx_byte[3:0];
            3'd1:    batt_lo   <= rx_byte;
            3'd2:    curr_hi   <= rx_byte[3:0];
            3'd3:    curr_lo   <= rx_byte;
            3'd4:    torque_hi <= rx_byte[3:0];
            default: ;
          endcase
          if (idx == LAST_IDX) begin
            telem.batt   <= {batt_hi, batt_lo};
            telem.curr   <= {curr_hi, curr_lo};
            telem.torque <= {torque_hi, rx_byte};
            pkt_state    <= HDR0;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: pkt_state <= HDR0;
      endcase
    end
  end

  // A completing packet beats a simultaneous acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_rdy <= 1'b0;
    end else if (pkt_done) begin
      pkt_rdy <= 1'b1;
    end else if (clr_rdy) begin
      pkt_rdy <= 1'b0;
    end
  end

  assign batt_v     = telem.batt;
  assign avg_curr   = telem.curr;
  assign avg_torque = telem.torque;

`ifdef TELEM_STATS_EN
  logic hdr_abort;

  assign hdr_abort = byte_done && (pkt_state == HDR1) &&
                     (rx_byte != HDR_BYTE1) && (rx_byte != HDR_BYTE0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (pkt_done) pkt_cnt <= pkt_cnt + 16'd1;
      if ((frm_err || hdr_abort) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
